vector_diff_stream: RTL

//  Streaming successor to the fixed 4-lane start/done difference unit.

---
 rtl/vector_diff_stream_pkg.sv | 15 +
 rtl/lane_reduce_stage.sv | 54 +++++
 rtl/vector_diff_stream.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vector_diff_stream_pkg.sv
// Shared definitions for the streaming vector difference unit.
// Reduction mode encodings and a constant-safe ceil(log2) helper.
package vdiff_defs;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_SUM = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/lane_reduce_stage.sv
// One registered level of the lane reduction tree: N entries in, N/2 out.
// Ports: clk, reset_n, en (pipe advance), mode, in_val/in_idx, out_val/out_idx.
module lane_reduce_stage
    import vdiff_defs::*;
#(
    parameter int W  = 6,
    parameter int IW = 2,
    parameter int N  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                mode,
    input  logic [N*W-1:0]      in_val,
    input  logic [N*IW-1:0]     in_idx,
    output logic [N/2*W-1:0]    out_val,
    output logic [N/2*IW-1:0]   out_idx
);

    localparam int M = N / 2;

    logic [M*W-1:0]  nxt_val;
    logic [M*IW-1:0] nxt_idx;

    // Pairs are (2j, 2j+1); the upper entry wins only when strictly larger,
    // so ties keep the lower lane index at every level.
    always_comb begin
        nxt_val = '0;
        nxt_idx = '0;
        for (int j = 0; j < M; j++) begin
            if (mode == MODE_SUM) begin
                nxt_val[j*W +: W]   = in_val[2*j*W +: W] + in_val[(2*j+1)*W +: W];
                nxt_idx[j*IW +: IW] = '0;
            end else if (in_val[(2*j+1)*W +: W] > in_val[2*j*W +: W]) begin
                nxt_val[j*W +: W]   = in_val[(2*j+1)*W +: W];
                nxt_idx[j*IW +: IW] = in_idx[(2*j+1)*IW +: IW];
            end else begin
                nxt_val[j*W +: W]   = in_val[2*j*W +: W];
                nxt_idx[j*IW +: IW] = in_idx[2*j*IW +: IW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_val <= '0;
            out_idx <= '0;
        end else if (en) begin
            out_val <= nxt_val;
            out_idx <= nxt_idx;
        end
    end

endmodule

// File: rtl/vector_diff_stream.sv
// Streaming per-lane |new - ref| with MAX(+index) or SUM reduction and threshold flag.
// Ports: clk, reset_n, in_valid/in_ready, vec_new, vec_old, use_prev, mode, thresh,
//        out_valid/out_ready, result, max_idx, over.
module vector_diff_stream
    import vdiff_defs::*;
#(
    parameter  int WIDTH = 4,
    parameter  int LANES = 4,
    localparam int LG    = clog2(LANES),
    localparam int RW    = WIDTH + LG
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] vec_new,
    input  logic [LANES*WIDTH-1:0] vec_old,
    input  logic                   use_prev,
    input  logic                   mode,
    input  logic [RW-1:0]          thresh,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RW-1:0]          result,
    output logic [LG-1:0]          max_idx,
    output logic                   over
);

    // Tree nodes stored level by level: leaves at 0, root at NODES-1.
    localparam int NODES = 2 * LANES - 1;

    logic                   ready_en;
    logic                   stall;
    logic                   en;
    logic                   accept;
    logic [LANES*WIDTH-1:0] prev_vec;
    logic [LANES*WIDTH-1:0] ref_vec;
    logic [LANES*WIDTH-1:0] diff;
    logic [LANES*WIDTH-1:0] diff_q;
    logic [NODES*RW-1:0]    node_val;
    logic [NODES*LG-1:0]    node_idx;
    logic                   valid_p  [0:LG];
    logic [RW-1:0]          thresh_p [0:LG];
    logic                   mode_p   [0:LG-1];

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    // Held low through reset and until the first clock after release.
    assign in_ready = ready_en && !stall;
    assign accept   = in_valid && in_ready;
    assign ref_vec  = use_prev ? prev_vec : vec_old;

    always_comb begin
        diff = '0;
        for (int i = 0; i < LANES; i++) begin
            if (vec_new[i*WIDTH +: WIDTH] >= ref_vec[i*WIDTH +: WIDTH])
                diff[i*WIDTH +: WIDTH] = vec_new[i*WIDTH +: WIDTH] - ref_vec[i*WIDTH +: WIDTH];
            else
                diff[i*WIDTH +: WIDTH] = ref_vec[i*WIDTH +: WIDTH] - vec_new[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    prev_vec <= '0;
        else if (accept) prev_vec <= vec_new;
    end

    // Stage 1 plus the sideband that travels alongside the tree levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            diff_q <= '0;
            for (int k = 0; k <= LG; k++) begin
                valid_p[k]  <= 1'b0;
                thresh_p[k] <= '0;
            end
            for (int k = 0; k < LG; k++) mode_p[k] <= MODE_MAX;
        end else if (en) begin
            diff_q      <= diff;
            valid_p[0]  <= accept;
            thresh_p[0] <= thresh;
            mode_p[0]   <= mode;
            for (int k = 1; k <= LG; k++) begin
                valid_p[k]  <= valid_p[k-1];
                thresh_p[k] <= thresh_p[k-1];
            end
            for (int k = 1; k < LG; k++) mode_p[k] <= mode_p[k-1];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_leaf
        assign node_val[i*RW +: RW] = {{LG{1'b0}}, diff_q[i*WIDTH +: WIDTH]};
        assign node_idx[i*LG +: LG] = LG'(i);
    end

    for (genvar k = 1; k <= LG; k++) begin : g_tree
        localparam int N  = LANES >> (k - 1);
        localparam int BI = 2 * LANES - 2 * N;
        localparam int BO = 2 * LANES - N;
        lane_reduce_stage #(.W(RW), .IW(LG), .N(N)) u_lvl (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en),
            .mode    (mode_p[k-1]),
            .in_val  (node_val[BI*RW +: N*RW]),
            .in_idx  (node_idx[BI*LG +: N*LG]),
            .out_val (node_val[BO*RW +: N/2*RW]),
            .out_idx (node_idx[BO*LG +: N/2*LG])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            max_idx   <= '0;
            over      <= 1'b0;
        end else if (en) begin
            out_valid <= valid_p[LG];
            result    <= node_val[(NODES-1)*RW +: RW];
            max_idx   <= node_idx[(NODES-1)*LG +: LG];
            over      <= node_val[(NODES-1)*RW +: RW] > thresh_p[LG];
        end
    end

endmodule
